// File: rtl/net_pkg.sv
`default_nettype none
// ============================================================================
// Module      : net_pkg
// Description : Shared types and constants for the network ingress datapath.
//               DATA_W  - byte lane width of the filter datapath
//               byte_t  - one byte lane
//               arb_state_t - packet arbiter FSM encoding (IDLE / BUSY)
// Revision    : 1.0 - initial release
// ============================================================================
package net_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] byte_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage : net_pkg
`default_nettype wire

// File: rtl/pkt_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : pkt_arbiter_if
// Description : Bundle of the NUM_PORTS ingress AXI-Stream lanes (s_*) and
//               the single egress lane (m_*) toward the MAC filter.
//               master : arbiter view (consumes s_*, drives m_*, s_tready)
//               slave  : environment view (drives s_*, m_tready)
// Revision    : 1.0 - initial release
// ============================================================================
interface pkt_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = net_pkg::DATA_W
);

    logic [NUM_PORTS-1:0]             s_tvalid;
    logic [NUM_PORTS-1:0][DATA_W-1:0] s_tdata;
    logic [NUM_PORTS-1:0]             s_tlast;
    logic [NUM_PORTS-1:0]             s_tready;

    logic                             m_tvalid;
    logic [DATA_W-1:0]                m_tdata;
    logic                             m_tlast;
    logic                             m_tready;

    modport master (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast
    );

    modport slave (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast
    );

endinterface : pkt_arbiter_if
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority selector. Returns the
//               first asserted req bit found scanning upward from rr_ptr,
//               wrapping modulo N.
//   req    in  [N]      request vector
//   rr_ptr in  [IDX_W]  highest-priority index (must be < N)
//   any    out 1        at least one request present
//   idx    out [IDX_W]  winning index (0 when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  wire logic [N-1:0]     req,
    input  wire logic [IDX_W-1:0] rr_ptr,
    output logic                  any,
    output logic [IDX_W-1:0]      idx
);

    int               w_pos;
    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest offset down to offset 0 so the last hit written
    // is the one closest to rr_ptr.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_pos  = 0;
        w_cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_pos = int'(rr_ptr) + i;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_cand = IDX_W'(w_pos);
            if (req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pkt_arbiter
// Description : Packet-granular round-robin AXI-Stream arbiter in front of
//               the MAC filter. A grant is held from the first beat through
//               the TLAST handshake, so packets never interleave.
//   clk      in   single clock, posedge
//   rst      in   synchronous active-high reset
//   bus      if   ingress s_* lanes and egress m_* lane (master modport)
//   busy     out  a packet grant is held (registered)
//   grant_id out  granted port index, valid while busy (registered)
//   pkt_cnt  out  per-port count of fully forwarded packets (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = net_pkg::DATA_W,
    parameter int CNT_W     = 16
) (
    input  wire logic                            clk,
    input  wire logic                            rst,
    pkt_arbiter_if.master                        bus,
    output logic                                 busy,
    output logic [$clog2(NUM_PORTS)-1:0]         grant_id,
    output logic [NUM_PORTS-1:0][CNT_W-1:0]      pkt_cnt
);

    import net_pkg::*;

    localparam int IDX_W = $clog2(NUM_PORTS);

    arb_state_t                        state_q,   state_d;
    logic [IDX_W-1:0]                  grant_q,   grant_d;
    logic [IDX_W-1:0]                  rr_ptr_q,  rr_ptr_d;
    logic [NUM_PORTS-1:0][CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic                              w_pick_any;
    logic [IDX_W-1:0]                  w_pick_idx;
    logic                              w_release;
    logic [IDX_W-1:0]                  w_next_ptr;

    rr_pick #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (bus.s_tvalid),
        .rr_ptr (rr_ptr_q),
        .any    (w_pick_any),
        .idx    (w_pick_idx)
    );

    // Egress mux steered by the registered grant. Everything is forced to
    // zero outside BUSY so the filter sees a clean idle bus.
    always_comb begin
        bus.s_tready = '0;
        bus.m_tvalid = 1'b0;
        bus.m_tdata  = '0;
        bus.m_tlast  = 1'b0;
        if (state_q == BUSY) begin
            bus.m_tvalid          = bus.s_tvalid[grant_q];
            bus.m_tdata           = bus.s_tdata[grant_q];
            bus.m_tlast           = bus.s_tlast[grant_q];
            bus.s_tready[grant_q] = bus.m_tready;
        end
    end

    assign w_release  = (state_q == BUSY) && bus.m_tvalid && bus.m_tready && bus.m_tlast;
    assign w_next_ptr = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            IDLE: begin
                if (w_pick_any) begin
                    grant_d = w_pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Other ports' requests are ignored until the granted
                // port's TLAST beat is accepted downstream.
                if (w_release) begin
                    state_d            = IDLE;
                    rr_ptr_d           = w_next_ptr;
                    pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign busy     = (state_q == BUSY);
    assign grant_id = grant_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule : pkt_arbiter
`default_nettype wire

// File: tb/tb_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_arbiter
// Description : Directed self-checking bench for pkt_arbiter (2 ports,
//               8-bit data, 4-bit packet counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_arbiter;

    import net_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  tv0, tv1, tl0, tl1, mrdy;
    byte_t td0, td1;

    always #5 clk = ~clk;

    pkt_arbiter_if #(.NUM_PORTS(2), .DATA_W(8)) bus ();

    assign bus.s_tvalid = {tv1, tv0};
    assign bus.s_tdata  = {td1, td0};
    assign bus.s_tlast  = {tl1, tl0};
    assign bus.m_tready = mrdy;

    logic            busy;
    logic [0:0]      grant_id;
    logic [1:0][3:0] pkt_cnt;

    pkt_arbiter #(
        .NUM_PORTS (2),
        .DATA_W    (8),
        .CNT_W     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id),
        .pkt_cnt  (pkt_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int    cyc       = 0;
    int    n_beats   = 0;
    int    lock_bad  = 0;
    int    busy_drop = 0;
    logic  in_pkt    = 1'b0;
    byte_t obs_d[$];
    bit    obs_l[$];
    int    obs_p[$];
    int    obs_c[$];
    byte_t ex_d[$];
    bit    ex_l[$];
    int    ex_p[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            in_pkt <= 1'b0;
        end else begin
            if (bus.m_tvalid && bus.m_tready) begin
                obs_d.push_back(bus.m_tdata);
                obs_l.push_back(bus.m_tlast);
                obs_p.push_back(int'(grant_id));
                obs_c.push_back(cyc);
                n_beats <= n_beats + 1;
                in_pkt  <= !bus.m_tlast;
            end
            if (in_pkt && !busy) busy_drop <= busy_drop + 1;
            if (busy && grant_id == 1'b0 && bus.s_tready[1]) lock_bad <= lock_bad + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic byte_t dat(input int seed, input int i);
        byte_t tbl [0:19];
        tbl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                8'hF0, 8'h0F, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        if (seed == 0) return tbl[i % 20];
        return byte_t'(seed + 7 * i);
    endfunction

    task automatic set_port(input int p, input logic v, input byte_t d, input logic l);
        if (p == 0) begin tv0 = v; td0 = d; tl0 = l; end
        else        begin tv1 = v; td1 = d; tl1 = l; end
    endtask

    function automatic logic sready(input int p);
        return (p == 0) ? bus.s_tready[0] : bus.s_tready[1];
    endfunction

    task automatic wait_hs(input int p);
        bit hs = 1'b0;
        int n  = 0;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = sready(p);
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) chk($sformatf("timeout_p%0d", p), 32'd0, 32'd1);
    endtask

    task automatic wait_nbeats(input int target);
        int n = 0;
        while (n_beats < target && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n_beats < target) chk("timeout_beats", 32'(n_beats), 32'(target));
    endtask

    task automatic send_pkt(input int p, input int len, input int seed,
                            input int gap_at, input int gap_len);
        for (int i = 0; i < len; i++) begin
            if (i == gap_at) begin
                set_port(p, 1'b0, 8'h00, 1'b0);
                repeat (gap_len) @(posedge clk);
                #1;
            end
            set_port(p, 1'b1, dat(seed, i), (i == len - 1));
            wait_hs(p);
        end
        set_port(p, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic expect_pkt(input int p, input int len, input int seed);
        for (int i = 0; i < len; i++) begin
            ex_d.push_back(dat(seed, i));
            ex_l.push_back(i == len - 1);
            ex_p.push_back(p);
        end
    endtask

    // Next packet must start exactly two cycles after the previous TLAST beat.
    task automatic chk_gaps(input string tag);
        for (int i = 1; i < obs_c.size(); i++) begin
            if (obs_l[i-1]) chk($sformatf("%s.gap%0d", tag, i), 32'(obs_c[i] - obs_c[i-1]), 32'd2);
        end
    endtask

    task automatic cmp_stream(input string tag);
        chk($sformatf("%s.beats", tag), 32'(obs_d.size()), 32'(ex_d.size()));
        for (int i = 0; i < ex_d.size() && i < obs_d.size(); i++) begin
            chk($sformatf("%s.d%0d", tag, i), 32'(obs_d[i]), 32'(ex_d[i]));
            chk($sformatf("%s.l%0d", tag, i), 32'(obs_l[i]), 32'(ex_l[i]));
            chk($sformatf("%s.p%0d", tag, i), 32'(obs_p[i]), 32'(ex_p[i]));
        end
        obs_d.delete(); obs_l.delete(); obs_p.delete(); obs_c.delete();
        ex_d.delete();  ex_l.delete();  ex_p.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".busy"},     32'(busy),         32'd0);
        chk({tag, ".grant"},    32'(grant_id),     32'd0);
        chk({tag, ".mvalid"},   32'(bus.m_tvalid), 32'd0);
        chk({tag, ".mdata"},    32'(bus.m_tdata),  32'd0);
        chk({tag, ".mlast"},    32'(bus.m_tlast),  32'd0);
        chk({tag, ".sready"},   32'(bus.s_tready), 32'd0);
        chk({tag, ".cnt"},      32'(pkt_cnt),      32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        rst  = 1'b1;
        mrdy = 1'b1;
        set_port(0, 1'b0, 8'h00, 1'b0);
        set_port(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single 20-byte packet on port 0
        expect_pkt(0, 20, 0);
        send_pkt(0, 20, 0, -1, 0);
        @(negedge clk);
        chk("single.busy_after", 32'(busy), 32'd0);
        chk("single.cnt0", 32'(pkt_cnt[0]), 32'd1);
        @(posedge clk);
        #1;
        cmp_stream("single");

        // Contention: reset so rr_ptr restarts at port 0
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_pkt(0, 4, 16 * (k + 1));
            expect_pkt(1, 4, 8'h90 + 16 * k);
        end
        fork
            begin
                for (int k = 0; k < 3; k++) send_pkt(0, 4, 16 * (k + 1), -1, 0);
            end
            begin
                for (int k = 0; k < 3; k++) send_pkt(1, 4, 8'h90 + 16 * k, -1, 0);
            end
        join
        @(negedge clk);
        chk("cont.cnt0", 32'(pkt_cnt[0]), 32'd3);
        chk("cont.cnt1", 32'(pkt_cnt[1]), 32'd3);
        @(posedge clk);
        #1;
        chk_gaps("cont");
        cmp_stream("cont");

        // Lock: port 1 requests during port 0's packet
        base = n_beats;
        expect_pkt(0, 6, 8'h50);
        expect_pkt(1, 3, 8'hC0);
        fork
            send_pkt(0, 6, 8'h50, -1, 0);
            begin
                wait_nbeats(base + 1);
                send_pkt(1, 3, 8'hC0, -1, 0);
            end
        join
        @(negedge clk);
        chk("lock.sready1", 32'(lock_bad), 32'd0);
        chk("lock.cnt1", 32'(pkt_cnt[1]), 32'd4);
        @(posedge clk);
        #1;
        chk_gaps("lock");
        cmp_stream("lock");

        // Backpressure at byte 5, source bubble at byte 10
        base = n_beats;
        expect_pkt(0, 12, 8'h60);
        fork
            send_pkt(0, 12, 8'h60, 9, 2);
            begin
                wait_nbeats(base + 4);
                mrdy = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                mrdy = 1'b1;
            end
        join
        @(negedge clk);
        chk("bp.busy_held", 32'(busy_drop), 32'd0);
        chk("bp.cnt0", 32'(pkt_cnt[0]), 32'd5);
        @(posedge clk);
        #1;
        cmp_stream("bp");

        // Reset while port 0 is presenting byte 7
        expect_pkt(0, 6, 8'h70);
        ex_l[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_port(0, 1'b1, dat(8'h70, i), 1'b0);
            wait_hs(0);
        end
        set_port(0, 1'b1, dat(8'h70, 6), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_port(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk_reset_vals("midrst");
        @(posedge clk);
        #1;
        cmp_stream("midrst");

        expect_pkt(1, 3, 8'hD0);
        send_pkt(1, 3, 8'hD0, -1, 0);
        @(negedge clk);
        chk("post.cnt1", 32'(pkt_cnt[1]), 32'd1);
        chk("post.cnt0", 32'(pkt_cnt[0]), 32'd0);
        @(posedge clk);
        #1;
        cmp_stream("post");

        // Counter wrap: 17 single-beat packets with 4-bit counters
        for (int k = 0; k < 17; k++) begin
            expect_pkt(0, 1, 8'h20 + k);
            send_pkt(0, 1, 8'h20 + k, -1, 0);
        end
        @(negedge clk);
        chk("wrap.cnt0", 32'(pkt_cnt[0]), 32'd1);
        chk("wrap.cnt1", 32'(pkt_cnt[1]), 32'd1);
        @(posedge clk);
        #1;
        chk_gaps("wrap");
        cmp_stream("wrap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pkt_arbiter
`default_nettype wire
